// File: rtl/wb_pkg.sv
// wb_pkg: load sizes, load-queue entry type and the load aligner shared by the write-back stage.
package wb_pkg;
  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [4:0]  waddr;
    logic [63:0] rdata;
    logic [2:0]  offset;
    logic [1:0]  size;
    logic        is_signed;
  } lq_entry_t;
  // A doubleword wraps 1<<3 to zero, so the mask becomes zero and eff_off is 0.
  function automatic logic [2:0] eff_off(input logic [2:0] off, input logic [1:0] size);
    return off & ~((3'd1 << size) - 3'd1);
  endfunction
  function automatic logic [63:0] ld_align(input lq_entry_t e);
    logic [63:0] d;
    d = e.rdata >> {eff_off(e.offset, e.size), 3'b000};
    return e.size == LD_B ? {{56{e.is_signed & d[7]}}, d[7:0]} :
           e.size == LD_H ? {{48{e.is_signed & d[15]}}, d[15:0]} :
           e.size == LD_W ? {{32{e.is_signed & d[31]}}, d[31:0]} : d;
  endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: synchronous FIFO with wrap-bit pointers for full/empty.
module wb_load_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout = mem_q[rp_q[AW-1:0]];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and queued load returns onto the register-file write port,
// tracks outstanding loads and throttles the ALU when loads starve.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [63:0] alu_wdata,
  input  logic [7:0]  alu_sel,
  output logic        alu_stall,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_addr,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_waddr,
  input  logic [63:0] ld_rdata,
  input  logic [2:0]  ld_offset,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_err,
  output logic [31:0] pend_mask,
  output logic        wena,
  output logic [4:0]  waddr,
  output logic [63:0] wdata,
  output logic [7:0]  sel
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);
  lq_entry_t push_e, head;
  logic full, empty, push, pop;
  logic wena_d, wena_q, ld_err_d, ld_err_q, alu_stall_d, alu_stall_q;
  logic [4:0] waddr_d, waddr_q;
  logic [63:0] wdata_d, wdata_q;
  logic [7:0] sel_d, sel_q;
  logic [31:0] pend_d, pend_q;
  logic [CW-1:0] starve_d, starve_q;
  assign push_e = '{waddr: ld_waddr, rdata: ld_rdata, offset: ld_offset, size: ld_size, is_signed: ld_signed};
  assign ld_ready = !full;
  assign push = ld_valid && !full;
  assign pop = !alu_valid && !empty;
  wb_load_fifo #(.DEPTH(LQ_DEPTH), .T(lq_entry_t)) u_lq (
    .clk(clk), .rst_n(rst_n), .push(push), .din(push_e), .pop(pop),
    .dout(head), .full(full), .empty(empty)
  );
  // Writes to r0 are dropped but still retire the load and clear its pending bit.
  always_comb begin
    wena_d = alu_valid ? alu_waddr != REG_ZERO : pop && head.waddr != REG_ZERO;
    waddr_d = alu_valid ? alu_waddr : pop ? head.waddr : waddr_q;
    wdata_d = alu_valid ? alu_wdata : pop ? ld_align(head) : wdata_q;
    sel_d = alu_valid ? alu_sel : pop ? 8'hFF : sel_q;
    ld_err_d = pop && eff_off(head.offset, head.size) != head.offset;
    pend_d = pend_q & ~(pop ? 32'd1 << head.waddr : 32'd0);
    if (ld_issue_valid && ld_issue_addr != REG_ZERO) pend_d[ld_issue_addr] = 1'b1;
    starve_d = (empty || pop) ? '0 : (starve_q != LIM) ? starve_q + CW'(1) : starve_q;
    alu_stall_d = !pop && (alu_stall_q || starve_d >= LIM);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wena_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      ld_err_q <= 1'b0;
      pend_q <= '0;
      starve_q <= '0;
      alu_stall_q <= 1'b0;
    end else begin
      wena_q <= wena_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sel_q <= sel_d;
      ld_err_q <= ld_err_d;
      pend_q <= pend_d;
      starve_q <= starve_d;
      alu_stall_q <= alu_stall_d;
    end
  end
  assign wena = wena_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign sel = sel_q;
  assign ld_err = ld_err_q;
  assign pend_mask = pend_q;
  assign alu_stall = alu_stall_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vectors, corner sequences and random traffic against a queue-based model.
module tb_reg_writeback;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid, ld_issue_valid, ld_valid, ld_signed;
  logic [4:0] alu_waddr, ld_issue_addr, ld_waddr;
  logic [63:0] alu_wdata, ld_rdata;
  logic [7:0] alu_sel;
  logic [2:0] ld_offset;
  logic [1:0] ld_size;
  logic alu_stall, ld_ready, ld_err, wena;
  logic [31:0] pend_mask;
  logic [4:0] waddr;
  logic [63:0] wdata;
  logic [7:0] sel;
  int errs = 0, checks = 0;

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .alu_sel(alu_sel), .alu_stall(alu_stall), .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_rdata(ld_rdata), .ld_offset(ld_offset),
    .ld_size(ld_size), .ld_signed(ld_signed), .ld_err(ld_err), .pend_mask(pend_mask), .wena(wena),
    .waddr(waddr), .wdata(wdata), .sel(sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [63:0] rdata;
    logic [2:0]  off;
    logic [1:0]  size;
    bit          sgn;
  } ld_t;
  ld_t lq[$];
  logic [31:0] m_pend;
  int m_starve;
  bit m_stall, m_wena, m_err;
  logic [4:0] m_waddr;
  logic [63:0] m_wdata;
  logic [7:0] m_sel;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load result from the byte-level description: round the offset down, shift, mask, extend.
  function automatic logic [63:0] ref_load(input ld_t e, output bit err);
    int bytes, eff;
    logic [63:0] v, mask;
    bytes = 1 << e.size;
    eff = int'(e.off) - (int'(e.off) % bytes);
    v = e.rdata >> (8 * eff);
    if (bytes < 8) begin
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      v = v & mask;
      if (e.sgn && v[8 * bytes - 1]) v = v | ~mask;
    end
    err = eff != int'(e.off);
    return v;
  endfunction

  task automatic model_reset();
    lq.delete();
    m_pend = '0; m_starve = 0; m_stall = 0; m_wena = 0; m_err = 0;
    m_waddr = '0; m_wdata = '0; m_sel = '0;
  endtask

  task automatic model_step();
    bit was_empty, was_full, do_pop, e;
    ld_t h, n;
    was_empty = lq.size() == 0;
    was_full = lq.size() == 4;
    do_pop = !alu_valid && !was_empty;
    m_err = 0;
    if (alu_valid) begin
      m_wena = alu_waddr != 0; m_waddr = alu_waddr; m_wdata = alu_wdata; m_sel = alu_sel;
    end else if (do_pop) begin
      h = lq.pop_front();
      m_wdata = ref_load(h, e);
      m_err = e; m_wena = h.waddr != 0; m_waddr = h.waddr; m_sel = 8'hFF;
      m_pend[h.waddr] = 1'b0;
    end else m_wena = 0;
    m_starve = (do_pop || was_empty) ? 0 : m_starve + 1;
    m_stall = !do_pop && (m_stall || m_starve >= 8);
    if (ld_issue_valid && ld_issue_addr != 0) m_pend[ld_issue_addr] = 1'b1;
    if (ld_valid && !was_full) begin
      n.waddr = ld_waddr; n.rdata = ld_rdata; n.off = ld_offset; n.size = ld_size; n.sgn = ld_signed;
      lq.push_back(n);
    end
  endtask

  task automatic check_all();
    chk("wena", 64'(wena), 64'(m_wena));
    chk("waddr", 64'(waddr), 64'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("sel", 64'(sel), 64'(m_sel));
    chk("ld_err", 64'(ld_err), 64'(m_err));
    chk("pend_mask", 64'(pend_mask), 64'(m_pend));
    chk("alu_stall", 64'(alu_stall), 64'(m_stall));
    chk("ld_ready", 64'(ld_ready), 64'(lq.size() < 4));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    alu_valid = 0; alu_waddr = '0; alu_wdata = '0; alu_sel = '0;
    ld_issue_valid = 0; ld_issue_addr = '0;
    ld_valid = 0; ld_waddr = '0; ld_rdata = '0; ld_offset = '0; ld_size = '0; ld_signed = 0;
  endtask

  task automatic push_ld(input logic [4:0] a, input logic [63:0] d, input logic [2:0] o, input logic [1:0] s, input bit g);
    ld_valid = 1; ld_waddr = a; ld_rdata = d; ld_offset = o; ld_size = s; ld_signed = g;
  endtask

  typedef struct {
    bit          alu;
    logic [4:0]  wa;
    logic [63:0] data;
    logic [7:0]  asel;
    logic [2:0]  off;
    logic [1:0]  size;
    bit          sgn;
    logic [63:0] exp_data;
    logic [7:0]  exp_sel;
    bit          exp_err;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5, 64'h1122334455667788, 8'h0F, 3'd0, 2'd0, 1'b0, 64'h1122334455667788, 8'h0F, 1'b0};
    vecs[1] = '{1'b0, 5'd7, 64'h0000000000800000, 8'h00, 3'd2, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 8'hFF, 1'b0};
    vecs[2] = '{1'b0, 5'd7, 64'h0000000000800000, 8'h00, 3'd2, 2'd0, 1'b0, 64'h0000000000000080, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 5'd3, 64'h89ABCDEF01234567, 8'h00, 3'd5, 2'd2, 1'b1, 64'hFFFFFFFF89ABCDEF, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 5'd10, 64'hBEEF000000000000, 8'h00, 3'd6, 2'd1, 1'b0, 64'h000000000000BEEF, 8'hFF, 1'b0};
    vecs[5] = '{1'b0, 5'd31, 64'h0123456789ABCDEF, 8'h00, 3'd3, 2'd3, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b1};
    vecs[6] = '{1'b0, 5'd2, 64'h0000000000008001, 8'h00, 3'd1, 2'd1, 1'b1, 64'hFFFFFFFFFFFF8001, 8'hFF, 1'b1};
    vecs[7] = '{1'b0, 5'd4, 64'hFFFFFFFF80000000, 8'h00, 3'd0, 2'd2, 1'b0, 64'h0000000080000000, 8'hFF, 1'b0};
    idle();
    model_reset();
    #3;
    check_all();
    #10;
    rst_n = 1;
    step();
    step();

    foreach (vecs[i]) begin
      idle();
      if (vecs[i].alu) begin
        alu_valid = 1; alu_waddr = vecs[i].wa; alu_wdata = vecs[i].data; alu_sel = vecs[i].asel;
      end else push_ld(vecs[i].wa, vecs[i].data, vecs[i].off, vecs[i].size, vecs[i].sgn);
      step();
      idle();
      if (!vecs[i].alu) step();
      chk($sformatf("vec%0d_wena", i), 64'(wena), 64'd1);
      chk($sformatf("vec%0d_waddr", i), 64'(waddr), 64'(vecs[i].wa));
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_sel", i), 64'(sel), 64'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_err", i), 64'(ld_err), 64'(vecs[i].exp_err));
      step();
      chk($sformatf("vec%0d_err_pulse", i), 64'(ld_err), 64'd0);
    end

    idle(); ld_issue_valid = 1; ld_issue_addr = 5'd9;
    step();
    chk("sb_set9", 64'(pend_mask), 64'h200);
    idle(); push_ld(5'd9, 64'hCAFEF00DDEADBEEF, 3'd0, 2'd3, 1'b0);
    step();
    idle();
    step();
    chk("sb_clear9", 64'(pend_mask), 64'h0);
    chk("sb_wena9", 64'(wena), 64'd1);
    idle(); ld_issue_valid = 1; ld_issue_addr = 5'd0; push_ld(5'd0, 64'h55, 3'd0, 2'd0, 1'b0);
    step();
    chk("r0_no_pend", 64'(pend_mask), 64'h0);
    idle();
    step();
    chk("r0_no_wena", 64'(wena), 64'd0);
    step();
    idle(); ld_issue_valid = 1; ld_issue_addr = 5'd12;
    step();
    idle(); push_ld(5'd12, 64'h1, 3'd0, 2'd3, 1'b0);
    step();
    idle(); ld_issue_valid = 1; ld_issue_addr = 5'd12;
    step();
    chk("set_wins", 64'(pend_mask[12]), 64'd1);
    idle(); push_ld(5'd12, 64'h2, 3'd0, 2'd3, 1'b0);
    step();
    idle();
    step();
    chk("r12_cleared", 64'(pend_mask), 64'h0);

    for (int i = 0; i < 4; i++) begin
      idle(); alu_valid = 1; alu_waddr = 5'(i + 1); alu_wdata = 64'(i); alu_sel = 8'hFF;
      push_ld(5'(20 + i), 64'(100 + i), 3'd0, 2'd3, 1'b0);
      step();
    end
    chk("lq_full_ready", 64'(ld_ready), 64'd0);
    idle(); alu_valid = 1; alu_waddr = 5'd6; alu_wdata = 64'h77; alu_sel = 8'h01;
    for (int i = 0; i < 4; i++) step();
    chk("stall_not_yet", 64'(alu_stall), 64'd0);
    step();
    chk("stall_rise", 64'(alu_stall), 64'd1);
    step();
    chk("stall_hold", 64'(alu_stall), 64'd1);
    idle();
    step();
    chk("stall_fall", 64'(alu_stall), 64'd0);
    chk("starve_pop_addr", 64'(waddr), 64'd20);
    chk("starve_ready", 64'(ld_ready), 64'd1);
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 3; i++) begin
      idle(); alu_valid = 1; alu_waddr = 5'd8; alu_wdata = 64'h99; alu_sel = 8'hF0;
      if (i < 2) begin ld_issue_valid = 1; ld_issue_addr = 5'(9 + i); end
      push_ld(5'(9 + i), 64'hABC, 3'd0, 2'd3, 1'b0);
      step();
    end
    chk("pre_reset_pend", 64'(pend_mask), 64'h600);
    idle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    #12;
    rst_n = 1;
    for (int i = 0; i < 4; i++) step();
    chk("post_reset_no_write", 64'(wena), 64'd0);

    for (int c = 0; c < 400; c++) begin
      alu_valid = $urandom_range(0, 99) < 40;
      alu_waddr = 5'($urandom); alu_wdata = {$urandom, $urandom}; alu_sel = 8'($urandom);
      ld_issue_valid = $urandom_range(0, 3) == 0; ld_issue_addr = 5'($urandom);
      push_ld(5'($urandom), {$urandom, $urandom}, 3'($urandom), 2'($urandom), 1'($urandom));
      ld_valid = $urandom_range(0, 1) == 1;
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
